br_resolve_ctrl: RTL and testbench

- Branch/jump resolution controller between the ID stage and IF.
- Accepts one decoded branch/jump op at a time (op codes per the `OP_* macros in defs.v) together with its instruction word, PC and the two source operands.
- Evaluates the condition and computes the target.
- For taken branches: drives a held redirect handshake to IF, pulses a younger-instruction flush, and emits the link-register writeback for BL/JIRL.

---
 rtl/br_resolve_ctrl.sv | 161 ++++++++++++++++
 tb/tb_br_resolve_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_ctrl.sv
// br_resolve_ctrl: resolves branch/jump ops handed over from ID.
// Evaluates condition and target, then drives redirect, flush and link writeback.
`ifndef OP_INVALID
`define OP_INVALID 8'h00
`define OP_JIRL    8'h01
`define OP_B       8'h02
`define OP_BL      8'h03
`define OP_BEQ     8'h04
`define OP_BNE     8'h05
`define OP_BLT     8'h06
`define OP_BGE     8'h07
`define OP_BLTU    8'h08
`define OP_BGEU    8'h09
`endif

module br_resolve_ctrl #(
   parameter int CNT_W    = 32,
   parameter int LINK_REG = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [7:0]       id_op,
   input  logic [31:0]      id_inst,
   input  logic [31:0]      id_pc,
   input  logic [31:0]      rj_val,
   input  logic [31:0]      rd_val,
   output logic             redir_valid,
   output logic [31:0]      redir_target,
   input  logic             redir_ack,
   output logic             flush,
   output logic             link_valid,
   output logic [4:0]       link_dest,
   output logic [31:0]      link_data,
   output logic [CNT_W-1:0] taken_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

   state_t      state;
   logic [7:0]  op_q;
   logic [25:0] inst_q;
   logic [31:0] pc_q;
   logic [31:0] rj_q;
   logic [31:0] rd_q;

   logic [31:0] offs16;
   logic [31:0] offs26;
   logic [31:0] target;
   logic [31:0] link_pc;
   logic        taken;
   logic        is_jirl, is_b, is_bl, is_beq, is_bne;
   logic        is_blt, is_bge, is_bltu, is_bgeu;
   logic        unused_inst;

   // Opcode field lives in inst[31:26]; the decoded op already carries it.
   assign unused_inst = ^id_inst[31:26];

   assign offs16  = {{14{inst_q[25]}}, inst_q[25:10], 2'b00};
   assign offs26  = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b00};
   assign link_pc = pc_q + 32'd4;

   assign is_jirl = (op_q == `OP_JIRL);
   assign is_b    = (op_q == `OP_B);
   assign is_bl   = (op_q == `OP_BL);
   assign is_beq  = (op_q == `OP_BEQ);
   assign is_bne  = (op_q == `OP_BNE);
   assign is_blt  = (op_q == `OP_BLT);
   assign is_bge  = (op_q == `OP_BGE);
   assign is_bltu = (op_q == `OP_BLTU);
   assign is_bgeu = (op_q == `OP_BGEU);

   always_comb begin
      taken  = 1'b0;
      target = pc_q + offs16;
      unique case (1'b1)
         is_jirl: begin
            taken  = 1'b1;
            target = rj_q + offs16;
         end
         is_b, is_bl: begin
            taken  = 1'b1;
            target = pc_q + offs26;
         end
         is_beq:  taken = (rj_q == rd_q);
         is_bne:  taken = (rj_q != rd_q);
         is_blt:  taken = ($signed(rj_q) < $signed(rd_q));
         is_bge:  taken = ($signed(rj_q) >= $signed(rd_q));
         is_bltu: taken = (rj_q < rd_q);
         is_bgeu: taken = (rj_q >= rd_q);
         default: taken = 1'b0;
      endcase
   end

   assign id_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         op_q         <= '0;
         inst_q       <= '0;
         pc_q         <= '0;
         rj_q         <= '0;
         rd_q         <= '0;
         redir_valid  <= 1'b0;
         redir_target <= '0;
         flush        <= 1'b0;
         link_valid   <= 1'b0;
         link_dest    <= '0;
         link_data    <= '0;
         taken_cnt    <= '0;
      end else begin
         flush      <= 1'b0;
         link_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (id_valid && id_op != `OP_INVALID) begin
                  op_q   <= id_op;
                  inst_q <= id_inst[25:0];
                  pc_q   <= id_pc;
                  rj_q   <= rj_val;
                  rd_q   <= rd_val;
                  state  <= EVAL;
               end
            end
            EVAL: begin
               if (taken) begin
                  state        <= REDIRECT;
                  redir_valid  <= 1'b1;
                  redir_target <= target;
                  flush        <= 1'b1;
                  if (is_bl) begin
                     link_valid <= 1'b1;
                     link_dest  <= 5'(LINK_REG);
                     link_data  <= link_pc;
                  end
                  if (is_jirl) begin
                     link_valid <= (inst_q[4:0] != 5'd0);
                     link_dest  <= inst_q[4:0];
                     link_data  <= link_pc;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            REDIRECT: begin
               if (redir_ack) begin
                  redir_valid <= 1'b0;
                  taken_cnt   <= taken_cnt + CNT_W'(1);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// tb_br_resolve_ctrl: directed and random checks of br_resolve_ctrl
// against a transaction-level reference model.
module tb_br_resolve_ctrl;

   localparam int CW = 4;
   localparam logic [7:0] OP_INVALID = 8'h00;
   localparam logic [7:0] OP_JIRL    = 8'h01;
   localparam logic [7:0] OP_B       = 8'h02;
   localparam logic [7:0] OP_BL      = 8'h03;
   localparam logic [7:0] OP_BEQ     = 8'h04;
   localparam logic [7:0] OP_BNE     = 8'h05;
   localparam logic [7:0] OP_BLT     = 8'h06;
   localparam logic [7:0] OP_BGE     = 8'h07;
   localparam logic [7:0] OP_BLTU    = 8'h08;
   localparam logic [7:0] OP_BGEU    = 8'h09;

   logic          clk = 1'b0;
   logic          resetn;
   logic          id_valid, id_ready;
   logic [7:0]    id_op;
   logic [31:0]   id_inst, id_pc, rj_val, rd_val;
   logic          redir_valid, redir_ack, flush, link_valid, busy;
   logic [31:0]   redir_target, link_data;
   logic [4:0]    link_dest;
   logic [CW-1:0] taken_cnt;

   br_resolve_ctrl #(.CNT_W(CW), .LINK_REG(1)) dut (
      .clk(clk), .resetn(resetn),
      .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
      .id_inst(id_inst), .id_pc(id_pc), .rj_val(rj_val), .rd_val(rd_val),
      .redir_valid(redir_valid), .redir_target(redir_target),
      .redir_ack(redir_ack), .flush(flush),
      .link_valid(link_valid), .link_dest(link_dest), .link_data(link_data),
      .taken_cnt(taken_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit cmp_on = 0;
   int ack_prob = 100;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h t=%0t", nm, got, exp, $time);
      end
   endtask

   typedef struct {
      bit          taken;
      logic [31:0] target;
      bit          lv;
      logic [4:0]  ld;
      logic [31:0] data;
   } res_t;

   function automatic res_t resolve(input logic [7:0] op,
                                    input logic [31:0] inst, pc, rj, rd);
      res_t r;
      logic signed [15:0] f16;
      logic signed [25:0] f26;
      logic [31:0] o16, o26;
      f16 = inst[25:10];
      f26 = {inst[9:0], inst[25:10]};
      o16 = 32'(int'(f16) * 4);
      o26 = 32'(int'(f26) * 4);
      r.taken  = 0;
      r.lv     = 0;
      r.ld     = inst[4:0];
      r.data   = pc + 32'd4;
      r.target = pc + o16;
      case (op)
         OP_B:    begin r.taken = 1; r.target = pc + o26; end
         OP_BL:   begin r.taken = 1; r.target = pc + o26; r.lv = 1; r.ld = 5'd1; end
         OP_JIRL: begin r.taken = 1; r.target = rj + o16; r.lv = (inst[4:0] != 0); end
         OP_BEQ:  r.taken = (rj == rd);
         OP_BNE:  r.taken = (rj != rd);
         OP_BLT:  r.taken = ($signed(rj) < $signed(rd));
         OP_BGE:  r.taken = ($signed(rj) >= $signed(rd));
         OP_BLTU: r.taken = (rj < rd);
         OP_BGEU: r.taken = (rj >= rd);
         default: r.taken = 0;
      endcase
      return r;
   endfunction

   // Model: one op in flight; age counts edges since it was accepted.
   bit   m_in = 0;
   int   m_age = 0;
   int   m_cnt = 0;
   res_t m_r;

   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         m_in = 0; m_age = 0; m_cnt = 0;
      end else if (m_in) begin
         if (m_age >= 2 && redir_ack) begin
            m_in = 0;
            m_cnt = (m_cnt + 1) % (1 << CW);
         end else if (m_age == 1 && !m_r.taken) begin
            m_in = 0;
         end else begin
            m_age++;
         end
      end else if (id_valid && id_op != OP_INVALID) begin
         m_in = 1;
         m_age = 1;
         m_r = resolve(id_op, id_inst, id_pc, rj_val, rd_val);
      end
   end

   initial begin
      bit rv, fl, lv;
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            rv = m_in && m_age >= 2;
            fl = m_in && m_age == 2;
            lv = fl && m_r.lv;
            chk("id_ready", 32'(id_ready), 32'(!m_in));
            chk("busy", 32'(busy), 32'(m_in));
            chk("redir_valid", 32'(redir_valid), 32'(rv));
            chk("flush", 32'(flush), 32'(fl));
            chk("link_valid", 32'(link_valid), 32'(lv));
            chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
            if (rv) chk("redir_target", redir_target, m_r.target);
            if (lv) begin
               chk("link_dest", 32'(link_dest), 32'(m_r.ld));
               chk("link_data", link_data, m_r.data);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      redir_ack = ($urandom_range(99) < ack_prob);
   end

   task automatic issue(input logic [7:0] op, input logic [31:0] inst, pc,
                        input logic [31:0] rj, rd);
      int n = 0;
      @(negedge clk);
      while (!id_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout got=busy exp=ready t=%0t", $time);
      end
      #1;
      id_valid = 1; id_op = op; id_inst = inst; id_pc = pc;
      rj_val = rj; rd_val = rd;
      @(posedge clk);
      #1;
      id_valid = 0;
   endtask

   logic [31:0] held;

   initial begin
      id_valid = 0; id_op = 0; id_inst = 0; id_pc = 0;
      rj_val = 0; rd_val = 0; redir_ack = 0;
      resetn = 1;
      #2 resetn = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(id_ready), 1);
      chk("rst_rv", 32'(redir_valid), 0);
      chk("rst_tgt", redir_target, 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_lv", 32'(link_valid), 0);
      chk("rst_ld", 32'(link_dest), 0);
      chk("rst_data", link_data, 0);
      chk("rst_cnt", 32'(taken_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
      cmp_on = 1;
      #1 resetn = 1;

      issue(OP_BEQ, 32'h0000_1000, 32'h1000, 5, 5);
      @(negedge clk);
      chk("beq_n1_busy", 32'(busy), 1);
      chk("beq_n1_rv", 32'(redir_valid), 0);
      @(negedge clk);
      chk("beq_rv", 32'(redir_valid), 1);
      chk("beq_tgt", redir_target, 32'h1010);
      chk("beq_flush", 32'(flush), 1);
      @(negedge clk);
      chk("beq_flush_end", 32'(flush), 0);
      chk("beq_cnt", 32'(taken_cnt), 1);
      chk("beq_ready", 32'(id_ready), 1);

      issue(OP_BLT, 32'h0000_1000, 32'h2000, 32'hFFFF_FFFF, 1);
      repeat (2) @(negedge clk);
      chk("blt_rv", 32'(redir_valid), 1);
      chk("blt_tgt", redir_target, 32'h2010);

      issue(OP_BLTU, 32'h0000_1000, 32'h2000, 32'hFFFF_FFFF, 1);
      @(negedge clk);
      chk("bltu_n1_ready", 32'(id_ready), 0);
      @(negedge clk);
      chk("bltu_ready", 32'(id_ready), 1);
      chk("bltu_flush", 32'(flush), 0);
      chk("bltu_rv", 32'(redir_valid), 0);

      issue(OP_BL, 32'h03FF_FFFF, 32'h1C00_0000, 0, 0);
      repeat (2) @(negedge clk);
      chk("bl_tgt", redir_target, 32'h1BFF_FFFC);
      chk("bl_lv", 32'(link_valid), 1);
      chk("bl_ld", 32'(link_dest), 1);
      chk("bl_data", link_data, 32'h1C00_0004);

      issue(OP_JIRL, 32'h0, 32'h3000, 32'h8000_0000, 0);
      repeat (2) @(negedge clk);
      chk("jirl0_tgt", redir_target, 32'h8000_0000);
      chk("jirl0_lv", 32'(link_valid), 0);

      issue(OP_JIRL, 32'h3, 32'h3000, 32'h8000_0000, 0);
      repeat (2) @(negedge clk);
      chk("jirl3_lv", 32'(link_valid), 1);
      chk("jirl3_ld", 32'(link_dest), 3);
      chk("jirl3_data", link_data, 32'h3004);
      @(negedge clk);
      chk("five_cnt", 32'(taken_cnt), 5);

      ack_prob = 0;
      issue(OP_B, 32'h0000_0800, 32'h4000, 0, 0);
      repeat (2) @(negedge clk);
      held = redir_target;
      chk("bp_tgt", held, 32'h4008);
      repeat (5) begin
         @(negedge clk);
         chk("bp_rv", 32'(redir_valid), 1);
         chk("bp_hold", redir_target, held);
         chk("bp_ready", 32'(id_ready), 0);
      end
      #1 resetn = 0;
      #1;
      chk("bp_rst_rv", 32'(redir_valid), 0);
      chk("bp_rst_cnt", 32'(taken_cnt), 0);
      chk("bp_rst_busy", 32'(busy), 0);
      chk("bp_rst_ready", 32'(id_ready), 1);
      @(negedge clk);
      #1 resetn = 1;
      ack_prob = 100;

      issue(OP_INVALID, 32'h0000_1000, 32'h5000, 1, 1);
      @(negedge clk);
      chk("inv_busy", 32'(busy), 0);
      chk("inv_rv", 32'(redir_valid), 0);
      chk("inv_flush", 32'(flush), 0);
      @(negedge clk);
      chk("inv_busy2", 32'(busy), 0);

      repeat (15) issue(OP_B, 32'h0000_0400, 32'h6000, 0, 0);
      repeat (4) @(negedge clk);
      chk("wrap_15", 32'(taken_cnt), 15);
      issue(OP_B, 32'h0000_0400, 32'h6000, 0, 0);
      repeat (4) @(negedge clk);
      chk("wrap_0", 32'(taken_cnt), 0);

      ack_prob = 60;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         id_valid = 1'($urandom_range(1));
         id_op    = 8'($urandom_range(9));
         id_inst  = $urandom;
         id_pc    = $urandom;
         rj_val   = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom;
         rd_val   = ($urandom_range(3) == 0) ? rj_val : $urandom;
         if ($urandom_range(3) == 0) rd_val = 32'($urandom_range(3));
         if (resetn == 0) resetn = 1;
         else if ($urandom_range(399) == 0) resetn = 0;
      end
      @(negedge clk);
      #1;
      id_valid = 0;
      resetn = 1;
      repeat (6) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
